// File: rtl/addr_data_gen_if.sv
// Burst request and beat bus between the generator (master) and its requester/consumer (slave).
interface addr_data_gen_if #(
  parameter int unsigned LEN_W = 8
);
  logic             start;
  logic [31:0]      base_addr;
  logic [31:0]      seed_data;
  logic [LEN_W-1:0] len;
  logic             hold;
  logic [31:0]      addr;
  logic [31:0]      data;
  logic             valid;
  logic             busy;
  logic             done;

  modport master (
    input  start, base_addr, seed_data, len, hold,
    output addr, data, valid, busy, done
  );

  modport slave (
    output start, base_addr, seed_data, len, hold,
    input  addr, data, valid, busy, done
  );
endinterface

// File: rtl/addr_data_gen.sv
// Burst address/data generator; define ADDR_DATA_GEN_LFSR_EN for Galois-LFSR data instead of +1.
// First beat one cycle after accepted start; hold=1 freezes the current beat for any duration.
module addr_data_gen #(
  parameter int unsigned ADDR_STEP = 4,
  parameter int unsigned LEN_W     = 8
) (
  input  logic           clk,
  input  logic           rst,
  addr_data_gen_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] count;

  function automatic logic [31:0] next_data(input logic [31:0] d);
`ifdef ADDR_DATA_GEN_LFSR_EN
    next_data = (d >> 1) ^ (d[0] ? 32'hE0000200 : 32'h0);
`else
    next_data = d + 32'd1;
`endif
  endfunction

  // An all-zero LFSR would lock up, so a zero seed is promoted to 1 in that build.
  function automatic logic [31:0] first_data(input logic [31:0] s);
`ifdef ADDR_DATA_GEN_LFSR_EN
    first_data = (s == 32'h0) ? 32'h00000001 : s;
`else
    first_data = s;
`endif
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      bus.addr  <= 32'h0;
      bus.data  <= 32'h0;
      bus.valid <= 1'b0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.busy <= 1'b1;
            if (bus.len != '0) begin
              state     <= BURST;
              bus.addr  <= bus.base_addr;
              bus.data  <= first_data(bus.seed_data);
              bus.valid <= 1'b1;
              count     <= bus.len;
            end else begin
              state    <= DONE;
              bus.done <= 1'b1;
            end
          end
        end
        BURST: begin
          if (!bus.hold) begin
            if (count == LEN_W'(1)) begin
              state     <= DONE;
              bus.valid <= 1'b0;
              bus.done  <= 1'b1;
              count     <= '0;
            end else begin
              bus.addr <= bus.addr + 32'(ADDR_STEP);
              bus.data <= next_data(bus.data);
              count    <= count - LEN_W'(1);
            end
          end
        end
        DONE: begin
          state    <= IDLE;
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
        end
        default: begin
          state     <= IDLE;
          bus.valid <= 1'b0;
          bus.busy  <= 1'b0;
          bus.done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_addr_data_gen.sv
// Directed bench for addr_data_gen: bursts, hold stalls, address wrap, zero length, async reset abort.
module tb_addr_data_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  addr_data_gen_if #(.LEN_W(8)) bus ();

  addr_data_gen #(.ADDR_STEP(4), .LEN_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Expected data of the following beat, hand-written for each build.
  function automatic logic [31:0] nd(input logic [31:0] d);
`ifdef ADDR_DATA_GEN_LFSR_EN
    nd = (d >> 1) ^ (d[0] ? 32'hE0000200 : 32'h0);
`else
    nd = d + 32'd1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_beat(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, ".valid"}, {31'h0, bus.valid}, 32'd1);
    chk({tag, ".busy"},  {31'h0, bus.busy},  32'd1);
    chk({tag, ".done"},  {31'h0, bus.done},  32'd0);
    chk({tag, ".addr"},  bus.addr, a);
    chk({tag, ".data"},  bus.data, d);
  endtask

  task automatic chk_ctl(input string tag, input logic v, input logic b, input logic dn);
    chk({tag, ".valid"}, {31'h0, bus.valid}, {31'h0, v});
    chk({tag, ".busy"},  {31'h0, bus.busy},  {31'h0, b});
    chk({tag, ".done"},  {31'h0, bus.done},  {31'h0, dn});
  endtask

  task automatic req(input logic [31:0] a, input logic [31:0] s, input logic [7:0] l);
    bus.start     = 1'b1;
    bus.base_addr = a;
    bus.seed_data = s;
    bus.len       = l;
  endtask

  initial begin
    bus.start = 1'b0; bus.base_addr = '0; bus.seed_data = '0; bus.len = '0; bus.hold = 1'b0;

    // Reset values
    #2 rst = 1'b0;
    #1;
    chk_ctl("rst_async", 1'b0, 1'b0, 1'b0);
    chk("rst_async.addr", bus.addr, 32'h0);
    tick();
    chk_ctl("rst_held", 1'b0, 1'b0, 1'b0);
    chk("rst_held.data", bus.data, 32'h0);
    rst = 1'b1;

    // Basic three-beat burst, then addr/data keep last values
    req(32'h1000, 32'hA0, 8'd3);
    tick(); bus.start = 1'b0;
    chk_beat("b1", 32'h1000, 32'hA0);
    tick(); chk_beat("b2", 32'h1004, nd(32'hA0));
    tick(); chk_beat("b3", 32'h1008, nd(nd(32'hA0)));
    tick(); chk_ctl("b_done", 1'b0, 1'b1, 1'b1);
    chk("b_done.addr", bus.addr, 32'h1008);
    chk("b_done.data", bus.data, nd(nd(32'hA0)));
    tick(); chk_ctl("b_idle", 1'b0, 1'b0, 1'b0);
    chk("b_idle.addr", bus.addr, 32'h1008);

    // Hold on beat 2 for two cycles, with an ignored start during the stall
    req(32'h2000, 32'h10, 8'd4);
    tick(); bus.start = 1'b0;
    chk_beat("h1", 32'h2000, 32'h10);
    tick(); chk_beat("h2", 32'h2004, nd(32'h10));
    bus.hold = 1'b1;
    req(32'h9990, 32'h55, 8'd7);
    tick(); chk_beat("h2_stall1", 32'h2004, nd(32'h10));
    tick(); chk_beat("h2_stall2", 32'h2004, nd(32'h10));
    bus.hold = 1'b0;
    tick(); chk_beat("h3", 32'h2008, nd(nd(32'h10)));
    bus.start = 1'b0;
    tick(); chk_beat("h4", 32'h200C, nd(nd(nd(32'h10))));
    tick(); chk_ctl("h_done", 1'b0, 1'b1, 1'b1);
    bus.hold = 1'b1;
    tick(); chk_ctl("h_idle_hold", 1'b0, 1'b0, 1'b0);
    bus.hold = 1'b0;

    // Address wrap past 2^32
    req(32'hFFFFFFF8, 32'hFFFFFFFF, 8'd3);
    tick(); bus.start = 1'b0;
    chk_beat("w1", 32'hFFFFFFF8, 32'hFFFFFFFF);
    tick(); chk_beat("w2", 32'hFFFFFFFC, nd(32'hFFFFFFFF));
    tick(); chk_beat("w3", 32'h00000000, nd(nd(32'hFFFFFFFF)));
    tick(); chk_ctl("w_done", 1'b0, 1'b1, 1'b1);
    tick(); chk_ctl("w_idle", 1'b0, 1'b0, 1'b0);

    // Zero-length request
    req(32'h5000, 32'h1, 8'd0);
    tick(); bus.start = 1'b0;
    chk_ctl("z_done", 1'b0, 1'b1, 1'b1);
    tick(); chk_ctl("z_idle", 1'b0, 1'b0, 1'b0);

    // Asynchronous reset during beat 2 of a five-beat burst
    req(32'h3000, 32'h50, 8'd5);
    tick(); bus.start = 1'b0;
    chk_beat("r1", 32'h3000, 32'h50);
    tick(); chk_beat("r2", 32'h3004, nd(32'h50));
    #2 rst = 1'b0;
    #1;
    chk_ctl("r_abort", 1'b0, 1'b0, 1'b0);
    chk("r_abort.addr", bus.addr, 32'h0);
    chk("r_abort.data", bus.data, 32'h0);
    tick(); chk_ctl("r_abort_held", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    req(32'h4000, 32'h77, 8'd1);
    tick(); bus.start = 1'b0;
    chk_beat("r_single", 32'h4000, 32'h77);
    tick(); chk_ctl("r_single_done", 1'b0, 1'b1, 1'b1);
    tick(); chk_ctl("r_single_idle", 1'b0, 1'b0, 1'b0);

`ifdef ADDR_DATA_GEN_LFSR_EN
    // LFSR sequence and zero-seed promotion
    req(32'h6000, 32'h1, 8'd3);
    tick(); bus.start = 1'b0;
    chk_beat("l1", 32'h6000, 32'h00000001);
    tick(); chk_beat("l2", 32'h6004, 32'hE0000200);
    tick(); chk_beat("l3", 32'h6008, 32'h70000100);
    tick(); tick();
    req(32'h7000, 32'h0, 8'd1);
    tick(); bus.start = 1'b0;
    chk_beat("l_zero_seed", 32'h7000, 32'h00000001);
    tick(); tick();
`else
    // Zero seed is used unchanged in the increment build
    req(32'h7000, 32'h0, 8'd2);
    tick(); bus.start = 1'b0;
    chk_beat("i_zero_seed", 32'h7000, 32'h0);
    tick(); chk_beat("i_zero_seed2", 32'h7004, 32'h1);
    tick(); tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
